panel_loader: RTL and testbench



---
 rtl/panel_loader.sv | 159 +++++++++++++++
 tb/tb_panel_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/panel_loader.sv
`timescale 1ns/1ps
// panel_loader
//   Front-panel word loader. Debounces three pushbuttons, composes a 32-bit
//   word from switch nibbles and writes it into CPU memory over a
//   request/acknowledge port.
//
// Ports
//   iClock      system clock, rising edge
//   iReset      asynchronous, active-low reset
//   iKeyDigit   raw key (0 = pressed): shift iNibble into the entry
//   iKeyWrite   raw key (0 = pressed): write entry / load address
//   iKeyClear   raw key (0 = pressed): clear the entry
//   iNibble     hex digit from the switches
//   iAddrLoad   1: a Write press loads the address register instead
//   iWrAck      memory acknowledge for the pending write
//   oEntry      word being composed
//   oDigits     nibbles entered, saturating at 8
//   oWrReq      write request, held until acknowledged
//   oWrAddr     current write address
//   oWrData     data of the pending write
//   oBusy       high while a write request is outstanding
module panel_loader #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iKeyDigit,
  input  logic                  iKeyWrite,
  input  logic                  iKeyClear,
  input  logic [3:0]            iNibble,
  input  logic                  iAddrLoad,
  input  logic                  iWrAck,
  output logic [31:0]           oEntry,
  output logic [3:0]            oDigits,
  output logic                  oWrReq,
  output logic [ADDR_WIDTH-1:0] oWrAddr,
  output logic [31:0]           oWrData,
  output logic                  oBusy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Key bit order throughout: [2] Clear, [1] Write, [0] Digit.
  logic [2:0]    w_key_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_db;
  logic [2:0]    r_db_d;
  logic [2:0]    r_evt;
  logic [CW-1:0] r_cnt [3];

  assign w_key_raw = {iKeyClear, iKeyWrite, iKeyDigit};

  // Debounced level only follows the synchronized level after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts.
  // The press pulse is registered from the debounced falling edge.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_db    <= '1;
      r_db_d  <= '1;
      r_evt   <= '0;
      for (int unsigned k = 0; k < 3; k++) r_cnt[k] <= '0;
    end else begin
      r_sync1 <= w_key_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      r_evt   <= r_db_d & ~r_db;
      for (int unsigned k = 0; k < 3; k++) begin
        if (r_sync2[k] == r_db[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_LAST) begin
          r_db[k]  <= r_sync2[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                r_state, w_state_nxt;
  logic [31:0]           r_entry, w_entry_nxt;
  logic [3:0]            r_digits, w_digits_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [31:0]           r_data, w_data_nxt;
  logic                  r_req, w_req_nxt;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_state  <= S_IDLE;
      r_entry  <= '0;
      r_digits <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_req    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_entry  <= w_entry_nxt;
      r_digits <= w_digits_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_req    <= w_req_nxt;
    end
  end

  // The if/else chain gives Clear > Write > Digit; lower events are dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_entry_nxt  = r_entry;
    w_digits_nxt = r_digits;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_req_nxt    = r_req;
    case (r_state)
      S_IDLE: begin
        if (r_evt[2]) begin
          w_entry_nxt  = '0;
          w_digits_nxt = '0;
        end else if (r_evt[1]) begin
          if (iAddrLoad) begin
            w_addr_nxt   = r_entry[ADDR_WIDTH-1:0];
            w_entry_nxt  = '0;
            w_digits_nxt = '0;
          end else begin
            w_data_nxt  = r_entry;
            w_req_nxt   = 1'b1;
            w_state_nxt = S_REQ;
          end
        end else if (r_evt[0]) begin
          w_entry_nxt  = {r_entry[27:0], iNibble};
          w_digits_nxt = (r_digits == 4'd8) ? 4'd8 : r_digits + 4'd1;
        end
      end
      S_REQ: begin
        if (iWrAck) begin
          w_req_nxt    = 1'b0;
          w_addr_nxt   = r_addr + 1'b1;
          w_entry_nxt  = '0;
          w_digits_nxt = '0;
          w_state_nxt  = S_IDLE;
        end
      end
    endcase
  end

  assign oEntry  = r_entry;
  assign oDigits = r_digits;
  assign oWrReq  = r_req;
  assign oWrAddr = r_addr;
  assign oWrData = r_data;
  assign oBusy   = (r_state == S_REQ);

endmodule

// File: tb/tb_panel_loader.sv
`timescale 1ns/1ps
// Testbench for panel_loader: directed scenarios plus randomized key
// sequences, checked against a word-level model of the loader.
module tb_panel_loader;

  localparam int AW = 8;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          kd = 1'b1, kw = 1'b1, kc = 1'b1;
  logic [3:0]    nib = 4'h0;
  logic          addr_load = 1'b0;
  logic          ack = 1'b0;
  logic [31:0]   oEntry;
  logic [3:0]    oDigits;
  logic          oWrReq;
  logic [AW-1:0] oWrAddr;
  logic [31:0]   oWrData;
  logic          oBusy;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_entry = '0;
  logic [3:0]  m_digits = '0;
  logic [7:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_req = 1'b0;

  panel_loader #(.ADDR_WIDTH(AW), .DEBOUNCE_CYCLES(DB)) dut (
    .iClock(clk), .iReset(rst_n),
    .iKeyDigit(kd), .iKeyWrite(kw), .iKeyClear(kc),
    .iNibble(nib), .iAddrLoad(addr_load), .iWrAck(ack),
    .oEntry(oEntry), .oDigits(oDigits), .oWrReq(oWrReq),
    .oWrAddr(oWrAddr), .oWrData(oWrData), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".entry"},  oEntry, m_entry);
    chk({tag, ".digits"}, {28'd0, oDigits}, {28'd0, m_digits});
    chk({tag, ".addr"},   {24'd0, oWrAddr}, {24'd0, m_addr});
    chk({tag, ".data"},   oWrData, m_data);
    chk({tag, ".req"},    {31'd0, oWrReq}, {31'd0, m_req});
    chk({tag, ".busy"},   {31'd0, oBusy}, {31'd0, m_req});
  endtask

  task automatic model_reset();
    m_entry = '0; m_digits = '0; m_addr = '0; m_data = '0; m_req = 1'b0;
  endtask

  // mask bits: [2] Clear, [1] Write, [0] Digit; highest one wins
  task automatic model_event(input logic [2:0] mask, input logic [3:0] n, input logic al);
    if (m_req) return;
    if (mask[2]) begin
      m_entry = '0; m_digits = '0;
    end else if (mask[1]) begin
      if (al) begin
        m_addr = m_entry[7:0]; m_entry = '0; m_digits = '0;
      end else begin
        m_data = m_entry; m_req = 1'b1;
      end
    end else if (mask[0]) begin
      m_entry = (m_entry << 4) | 32'(n);
      if (m_digits < 4'd8) m_digits = m_digits + 4'd1;
    end
  endtask

  task automatic press(input logic [2:0] mask, input logic [3:0] n);
    @(negedge clk);
    nib = n;
    kc = ~mask[2]; kw = ~mask[1]; kd = ~mask[0];
    repeat (10) @(negedge clk);
    kc = 1'b1; kw = 1'b1; kd = 1'b1;
    repeat (10) @(negedge clk);
    model_event(mask, n, addr_load);
  endtask

  task automatic do_ack(input int delay);
    repeat (delay) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    if (m_req) begin
      m_req = 1'b0; m_addr = m_addr + 8'd1; m_entry = '0; m_digits = '0;
    end
  endtask

  task automatic enter_word(input logic [31:0] w, input int ndig);
    logic [31:0] v;
    v = w;
    for (int i = ndig - 1; i >= 0; i--) press(3'b001, 4'(v >> (4 * i)));
  endtask

  initial begin
    int lat;
    logic [31:0] old;

    // Power-on reset
    repeat (3) @(negedge clk);
    check_all("reset0");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Digit entry with latency measurement on the first press
    old = oEntry;
    nib = 4'h1;
    kd = 1'b0;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      if (oEntry !== old) begin
        lat = i;
        break;
      end
    end
    chk("press_latency", lat, 8);
    repeat (3) @(negedge clk);
    kd = 1'b1;
    repeat (10) @(negedge clk);
    model_event(3'b001, 4'h1, 1'b0);
    for (int i = 2; i <= 9; i++) press(3'b001, 4'(i));
    chk("sat.entry_const", oEntry, 32'h23456789);
    chk("sat.digits_const", {28'd0, oDigits}, 32'd8);
    check_all("saturate");

    // Asynchronous reset mid-run
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Debounce: short glitch ignored, long hold gives one shift
    nib = 4'h5;
    kd = 1'b0;
    repeat (3) @(negedge clk);
    kd = 1'b1;
    repeat (10) @(negedge clk);
    check_all("glitch");
    kd = 1'b0;
    repeat (50) @(negedge clk);
    kd = 1'b1;
    repeat (10) @(negedge clk);
    model_event(3'b001, 4'h5, 1'b0);
    check_all("long_hold");

    // Address load and write
    press(3'b100, 4'h0);
    enter_word(32'h10, 2);
    addr_load = 1'b1;
    press(3'b010, 4'h0);
    chk("addrload.addr_const", {24'd0, oWrAddr}, 32'h10);
    check_all("addrload");
    addr_load = 1'b0;
    enter_word(32'hCAFE, 4);
    press(3'b010, 4'h0);
    chk("write.data_const", oWrData, 32'h0000CAFE);
    check_all("write_req");
    repeat (5) @(negedge clk);
    press(3'b001, 4'h7);
    check_all("req_hold");
    do_ack(0);
    chk("ack.addr_const", {24'd0, oWrAddr}, 32'h11);
    check_all("ack");
    do_ack(2);
    check_all("ack_idle_ignored");

    // Address wrap
    enter_word(32'hFF, 2);
    addr_load = 1'b1;
    press(3'b010, 4'h0);
    addr_load = 1'b0;
    enter_word(32'h3C, 2);
    press(3'b010, 4'h0);
    check_all("wrap_req");
    do_ack(1);
    chk("wrap.addr_const", {24'd0, oWrAddr}, 32'h0);
    check_all("wrap");

    // Simultaneous Clear + Digit, Write + Digit
    enter_word(32'hAB, 2);
    press(3'b101, 4'h9);
    check_all("clr_dig");
    enter_word(32'h12, 2);
    press(3'b011, 4'h4);
    check_all("wr_dig");

    // Reset during an outstanding request
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset_in_req");
    @(negedge clk);
    rst_n = 1'b1;
    ack = 1'b1;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    check_all("ack_after_reset");

    // Randomized entry / address load / write sequences
    for (int it = 0; it < 6; it++) begin
      int nd;
      nd = $urandom_range(1, 10);
      for (int d = 0; d < nd; d++) press(3'b001, 4'($urandom_range(0, 15)));
      check_all("rnd_entry");
      addr_load = ($urandom_range(0, 2) == 0);
      press(3'b010, 4'h0);
      addr_load = 1'b0;
      check_all("rnd_write");
      if ($urandom_range(0, 1) == 1) press(3'b001, 4'($urandom_range(0, 15)));
      do_ack($urandom_range(0, 6));
      check_all("rnd_ack");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
